// File: rtl/multi_clk_gen_pkg.sv
// rtl/multi_clk_gen_pkg.sv - default constants and per-channel config type for multi_clk_gen
package multi_clk_gen_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_W        = 32;
    localparam int DEF_UNIT_NS  = 2;
    localparam int DEF_HALF_NS  = 1000;

    // Config fields are carried at a fixed maximum width; channels use the low W bits.
    localparam int CFG_MAX_W = 64;

    typedef struct packed {
        logic [CFG_MAX_W-1:0] half;
        logic [CFG_MAX_W-1:0] phase;
    } chan_cfg_t;

    function automatic int chan_sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// rtl/clk_gen_chan.sv - one generated clock: remainder-carrying accumulator, shadow config, restart
// Phase registers exist only when MULTI_CLK_GEN_PHASE_EN is defined.
module clk_gen_chan
    import multi_clk_gen_pkg::*;
#(
    parameter int W               = DEF_W,
    parameter int UNIT_NS         = DEF_UNIT_NS,
    parameter int DEFAULT_HALF_NS = DEF_HALF_NS
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_active,
    input  logic      i_sync,
    input  logic      i_wr,
    input  chan_cfg_t i_cfg,
    output logic      o_pending,
    output logic      o_clk,
    output logic      o_tick
);

    logic [W-1:0] r_acc;
    logic [W-1:0] r_half;
    logic [W-1:0] r_sh_half;
    logic         r_pending;
    logic         r_prev_active;
    logic         r_clk;
    logic         r_tick;

    logic [W-1:0] w_phase;
    logic [W-1:0] w_new_phase;
    logic [W-1:0] w_new_half;
    logic [W-1:0] w_start_acc;
    logic [W:0]   w_sum;
    logic [W:0]   w_rem;
    logic         w_hit;
    logic         w_restart;
    logic         w_apply;
    logic         w_unused;

    assign w_sum     = {1'b0, r_acc} + (W+1)'(UNIT_NS);
    assign w_rem     = w_sum - {1'b0, r_half};
    assign w_hit     = (w_sum >= {1'b0, r_half});
    assign w_restart = i_sync | (i_active & ~r_prev_active);
    // Shadow config lands only at a period boundary, a restart, or while stopped.
    assign w_apply   = r_pending & (w_restart | ~i_active | w_hit);

`ifdef MULTI_CLK_GEN_PHASE_EN
    logic [W-1:0] r_phase;
    logic [W-1:0] r_sh_phase;

    assign w_phase     = r_phase;
    assign w_new_phase = r_pending ? r_sh_phase : r_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_sh_phase <= '0;
        end else begin
            if (i_wr) begin
                r_sh_phase <= i_cfg.phase[W-1:0];
            end
            if (w_apply) begin
                r_phase <= r_sh_phase;
            end
        end
    end
`else
    assign w_phase     = '0;
    assign w_new_phase = '0;
`endif

    assign w_new_half  = r_pending ? r_sh_half : r_half;
    assign w_start_acc = (w_new_phase < w_new_half) ? w_new_phase : (w_new_half - 1'b1);
    assign w_unused    = ^{i_cfg, w_rem[W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc         <= '0;
            r_half        <= W'(DEFAULT_HALF_NS);
            r_sh_half     <= W'(DEFAULT_HALF_NS);
            r_pending     <= 1'b0;
            r_prev_active <= 1'b0;
            r_clk         <= 1'b0;
            r_tick        <= 1'b0;
        end else begin
            r_prev_active <= i_active;
            if (i_wr) begin
                r_sh_half <= i_cfg.half[W-1:0];
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
            if (w_apply) begin
                r_half <= r_sh_half;
            end

            if (w_restart) begin
                r_acc  <= w_start_acc;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (!i_active) begin
                r_acc  <= w_phase;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_hit) begin
                r_acc  <= w_rem[W-1:0];
                r_clk  <= ~r_clk;
                r_tick <= 1'b1;
            end else begin
                r_acc  <= w_sum[W-1:0];
                r_tick <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_clk     = r_clk;
    assign o_tick    = r_tick;

endmodule

// File: rtl/multi_clk_gen.sv
// rtl/multi_clk_gen.sv - multi-channel fractional clock generator with glitch-free config updates
// Optional phase offsets are enabled by defining MULTI_CLK_GEN_PHASE_EN.
module multi_clk_gen
    import multi_clk_gen_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int W               = DEF_W,
    parameter int UNIT_NS         = DEF_UNIT_NS,
    parameter int DEFAULT_HALF_NS = DEF_HALF_NS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [CHANNELS-1:0]                  chan_en,
    input  logic                                 sync,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [chan_sel_width(CHANNELS)-1:0]  cfg_chan,
    input  logic [W-1:0]                         cfg_half_ns,
    input  logic [W-1:0]                         cfg_phase_ns,
    output logic [CHANNELS-1:0]                  clk_out,
    output logic [CHANNELS-1:0]                  tick,
    output logic                                 cfg_err
);

    localparam int CW    = chan_sel_width(CHANNELS);
    localparam int SEL_N = 1 << CW;

    logic [CHANNELS-1:0] w_active;
    logic [CHANNELS-1:0] w_pending;
    logic [CHANNELS-1:0] w_wr;
    logic [SEL_N-1:0]    w_pending_pad;
    logic                w_in_range;
    logic                w_bad;
    logic                w_accept;
    chan_cfg_t           w_cfg;
    logic                r_cfg_err;

    assign w_active   = chan_en & {CHANNELS{enable}};
    assign w_in_range = ({1'b0, cfg_chan} < (CW+1)'(CHANNELS));

    // Out-of-range selects see a zero pending bit, so they are accepted and then rejected.
    assign w_pending_pad = SEL_N'(w_pending);
    assign cfg_ready     = ~w_pending_pad[cfg_chan];
    assign w_accept      = cfg_valid & cfg_ready;
    assign w_bad         = ~w_in_range | (cfg_half_ns < W'(UNIT_NS));

`ifdef MULTI_CLK_GEN_PHASE_EN
    assign w_cfg = '{half: CFG_MAX_W'(cfg_half_ns), phase: CFG_MAX_W'(cfg_phase_ns)};
`else
    logic w_unused_phase;
    assign w_unused_phase = ^cfg_phase_ns;
    assign w_cfg = '{half: CFG_MAX_W'(cfg_half_ns), phase: '0};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & w_bad;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign w_wr[gi] = w_accept & ~w_bad & (cfg_chan == CW'(gi));

        clk_gen_chan #(
            .W              (W),
            .UNIT_NS        (UNIT_NS),
            .DEFAULT_HALF_NS(DEFAULT_HALF_NS)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .i_active (w_active[gi]),
            .i_sync   (sync),
            .i_wr     (w_wr[gi]),
            .i_cfg    (w_cfg),
            .o_pending(w_pending[gi]),
            .o_clk    (clk_out[gi]),
            .o_tick   (tick[gi])
        );
    end

endmodule

// File: tb/tb_multi_clk_gen.sv
// tb/tb_multi_clk_gen.sv - scoreboard bench for multi_clk_gen with a behavioural reference model
module tb_multi_clk_gen;

    localparam int CH   = 3;
    localparam int W    = 16;
    localparam int UNIT = 2;
    localparam int DEFH = 6;
`ifdef MULTI_CLK_GEN_PHASE_EN
    localparam bit PHASE_ON = 1'b1;
`else
    localparam bit PHASE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [CH-1:0] chan_en;
    logic          sync;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [W-1:0]  cfg_half_ns;
    logic [W-1:0]  cfg_phase_ns;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic          cfg_err;

    always #5 clk = ~clk;

    multi_clk_gen #(
        .CHANNELS       (CH),
        .W              (W),
        .UNIT_NS        (UNIT),
        .DEFAULT_HALF_NS(DEFH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .chan_en     (chan_en),
        .sync        (sync),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_half_ns (cfg_half_ns),
        .cfg_phase_ns(cfg_phase_ns),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_err     (cfg_err)
    );

    typedef struct {
        logic          ready;
        logic [CH-1:0] clk;
        logic [CH-1:0] tick;
        logic          err;
        string         tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time in ns accumulates per cycle, wrapping by the half period with carry.
    longint m_acc[CH];
    longint m_half[CH];
    longint m_phase[CH];
    longint m_sh_half[CH];
    longint m_sh_phase[CH];
    bit     m_pend[CH];
    bit     m_clk[CH];
    bit     m_tick[CH];
    bit     m_prev[CH];
    bit     m_err;

    function automatic bit m_ready(input int c);
        return (c >= CH) ? 1'b1 : !m_pend[c];
    endfunction

    task automatic m_apply(input int i);
        m_half[i]  = m_sh_half[i];
        m_phase[i] = PHASE_ON ? m_sh_phase[i] : 0;
        m_pend[i]  = 1'b0;
    endtask

    task automatic model_edge();
        int c;
        bit take;
        bit bad;
        bit act;
        bit restart;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_acc[i] = 0; m_half[i] = DEFH; m_phase[i] = 0;
                m_sh_half[i] = DEFH; m_sh_phase[i] = 0;
                m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0; m_prev[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            c    = int'(cfg_chan);
            take = cfg_valid && m_ready(c);
            bad  = (c >= CH) || (int'(cfg_half_ns) < UNIT);
            for (int i = 0; i < CH; i++) begin
                act     = enable && chan_en[i];
                restart = sync || (act && !m_prev[i]);
                if (restart) begin
                    if (m_pend[i]) m_apply(i);
                    m_acc[i]  = (m_phase[i] < m_half[i]) ? m_phase[i] : m_half[i] - 1;
                    m_clk[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                end else if (!act) begin
                    m_acc[i]  = m_phase[i];
                    m_clk[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                    if (m_pend[i]) m_apply(i);
                end else if (m_acc[i] + UNIT >= m_half[i]) begin
                    m_acc[i]  = m_acc[i] + UNIT - m_half[i];
                    m_clk[i]  = !m_clk[i];
                    m_tick[i] = 1'b1;
                    if (m_pend[i]) m_apply(i);
                end else begin
                    m_acc[i]  = m_acc[i] + UNIT;
                    m_tick[i] = 1'b0;
                end
                m_prev[i] = act;
            end
            if (take && !bad) begin
                m_sh_half[c]  = longint'(cfg_half_ns);
                m_sh_phase[c] = longint'(cfg_phase_ns);
                m_pend[c]     = 1'b1;
            end
            m_err = take && bad;
        end
    endtask

    // Inputs are already applied; queue what the DUT must show this cycle, then advance.
    task automatic step(input string tag);
        exp_t e;
        e.ready = m_ready(int'(cfg_chan));
        for (int i = 0; i < CH; i++) begin
            e.clk[i]  = m_clk[i];
            e.tick[i] = m_tick[i];
        end
        e.err = m_err;
        e.tag = tag;
        q.push_back(e);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic cfg_write(input int c, input int h, input int p, input string tag);
        int n;
        n            = 0;
        cfg_valid    = 1'b1;
        cfg_chan     = 2'(c);
        cfg_half_ns  = W'(h);
        cfg_phase_ns = W'(p);
        while (!m_ready(c) && n < 200) begin
            step(tag);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: write to channel %0d not accepted within %0d cycles", tag, c, n);
        end
        step(tag);
        cfg_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({cfg_ready, clk_out, tick, cfg_err} !== {e.ready, e.clk, e.tick, e.err}) begin
                    errors++;
                    $display("FAIL %s @%0t: got ready=%b clk_out=%b tick=%b cfg_err=%b, want ready=%b clk_out=%b tick=%b cfg_err=%b",
                             e.tag, $time, cfg_ready, clk_out, tick, cfg_err,
                             e.ready, e.clk, e.tick, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        reset = 1'b1; enable = 1'b0; chan_en = '0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_chan = '0; cfg_half_ns = '0; cfg_phase_ns = '0;
        repeat (2) @(posedge clk);
        #1;
        model_edge();
        run(2, "reset_state");

        reset = 1'b0; enable = 1'b1; chan_en = 3'b001;
        run(10, "default_half");
        cfg_write(0, 10, 0, "half10_write");
        run(30, "half10_period");
        cfg_write(0, 5, 0, "half5_write");
        run(30, "half5_carry");
        run(2, "half20_mid");
        cfg_write(0, 20, 0, "half20_write");
        run(45, "half20_period");

        cfg_write(0, 1, 0, "err_small_half");
        run(3, "err_small_half");
        cfg_write(3, 10, 0, "err_bad_chan");
        run(3, "err_bad_chan");

        chan_en = 3'b011;
        cfg_write(0, 10, 0, "phase_write");
        cfg_write(1, 10, 4, "phase_write");
        run(3, "phase_pre");
        sync = 1'b1;
        step("phase_sync");
        sync = 1'b0;
        run(40, "phase_aligned");

        chan_en = 3'b111;
        run(3, "enable_edge");
        enable = 1'b0;
        run(3, "disabled");
        enable = 1'b1;
        run(12, "reenabled");

        cfg_write(0, 12, 2, "reset_pending");
        run(1, "reset_pending");
        reset = 1'b1; cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_half_ns = W'(9);
        step("reset_mid");
        reset = 1'b0; cfg_valid = 1'b0;
        run(12, "after_reset");

        for (int k = 0; k < 2500; k++) begin
            r            = int'($urandom_range(0, 99));
            reset        = (r == 0);
            sync         = (r >= 1 && r <= 3);
            if ($urandom_range(0, 39) == 0) enable = !enable;
            if ($urandom_range(0, 29) == 0) chan_en = CH'($urandom);
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_chan     = 2'($urandom);
            cfg_half_ns  = W'($urandom_range(0, 14));
            cfg_phase_ns = W'($urandom_range(0, 16));
            step("random");
        end
        reset = 1'b0; sync = 1'b0; cfg_valid = 1'b0;

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected records left unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_clk_gen.md
MULTI_CLK_GEN -- requirements
Module: multi_clk_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent generated clocks, 1..16.
REQ-002 SHALL have parameter W, default 32: width of the half-period, phase and accumulator fields, in ns.
REQ-003 SHALL have parameter UNIT_NS, default 2: ns added per clk cycle, nonzero, less than 2^(W-1).
REQ-004 SHALL have parameter DEFAULT_HALF_NS, default 1000: half-period value loaded at reset, at least UNIT_NS.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic samples on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: global run gate.
REQ-008 SHALL have port chan_en, input, CHANNELS: per-channel run gate.
REQ-009 SHALL have port sync, input, 1: one-cycle pulse that restarts all channels phase-aligned.
REQ-010 SHALL have port cfg_valid, input, 1: configuration write request.
REQ-011 SHALL have port cfg_ready, output, 1: configuration write can be accepted.
REQ-012 SHALL have port cfg_chan, input, clog2(CHANNELS) (min 1): target channel.
REQ-013 SHALL have port cfg_half_ns, input, W: new half-period in ns.
REQ-014 SHALL have port cfg_phase_ns, input, W: new phase offset in ns.
REQ-015 SHALL have port clk_out, output, CHANNELS: generated clocks.
REQ-016 SHALL have port tick, output, CHANNELS: one-cycle pulse in the cycle each clk_out bit toggles.
REQ-017 SHALL have port cfg_err, output, 1: one-cycle pulse marking a rejected write.

Function
REQ-018 A channel SHALL be active when enable and chan_en[i] are both 1.
REQ-019 For an active channel, each cycle: if acc+UNIT_NS >= half, then clk_out[i] toggles, tick[i]=1 and acc <= acc+UNIT_NS-half (the remainder is carried, not zeroed); otherwise acc <= acc+UNIT_NS and tick[i]=0.
REQ-020 Accumulator arithmetic SHALL be W+1 bits wide internally; no wrap is permitted.
REQ-021 For an inactive channel: clk_out[i]=0, tick[i]=0, and acc is held at its phase value.
REQ-022 The first toggle after activation SHALL occur on the first cycle in which the REQ-019 condition holds; clk_out starts at 0.
REQ-023 cfg_ready SHALL equal !pending[cfg_chan]; it is combinational from cfg_chan.
REQ-024 A write is accepted on cfg_valid & cfg_ready; any cfg_chan >= CHANNELS SHALL be rejected.
REQ-025 An accepted write with cfg_half_ns < UNIT_NS SHALL be discarded, pulse cfg_err the next cycle, and set no pending flag.
REQ-026 An otherwise accepted write SHALL be stored in the channel's shadow register and set pending[i].
REQ-027 A pending update SHALL be applied in the cycle the channel toggles, at the period boundary, so no glitch occurs; the toggle in that cycle uses the old half value.
REQ-028 If the channel is inactive, the pending update SHALL be applied the cycle after acceptance.
REQ-029 Applying an update SHALL load half and phase, clear pending[i], and leave acc unchanged.
REQ-030 On sync: every channel loads acc <= min(phase, half-1), sets clk_out=0 and tick=0, and applies any pending update first.
REQ-031 sync SHALL override a toggle in the same cycle.
REQ-032 A rising edge of chan_en[i] or of enable SHALL apply the same per-channel restart as sync.
REQ-033 tick SHALL have one-cycle latency from the accumulator compare, registered together with clk_out.

Reset
REQ-034 During reset: clk_out=0, tick=0, cfg_err=0, acc=0, pending=0, half=DEFAULT_HALF_NS, phase=0.
REQ-035 reset SHALL take priority over all other inputs; a write in progress is dropped.

Configuration
REQ-036 Macro MULTI_CLK_GEN_PHASE_EN, when defined, SHALL implement the phase registers and restart loading per REQ-030.
REQ-037 When MULTI_CLK_GEN_PHASE_EN is undefined, cfg_phase_ns SHALL be ignored, the phase registers SHALL be removed, and every restart loads acc=0.

Structure
REQ-038 Shared package multi_clk_gen_pkg SHALL hold the default parameter constants and the per-channel config struct {half, phase}.
REQ-039 Per-channel logic SHALL be the sub-module clk_gen_chan, instantiated CHANNELS times; the top level holds the cfg handshake and decode.

Verification
REQ-040 UNIT=2, half=10, chan 0 active -> clk_out[0] toggles every 5 cycles (period 10), tick[0] pulses each toggle.
REQ-041 UNIT=2, half=5 -> toggle intervals alternate 3,2,3,2 cycles; the remainder carry is exact.
REQ-042 Write half=20 mid-period to an active channel -> cfg_ready=0 until the next toggle; the new interval of 10 cycles starts after that toggle; no short pulse.
REQ-043 Write half=1 with UNIT=2 -> cfg_err pulses once; the channel is unchanged; a write with cfg_chan=CHANNELS also pulses cfg_err.
REQ-044 Phase feature on, ch0 phase=0, ch1 phase=4, both half=10, pulse sync -> ch1 toggles 2 cycles before ch0 every period.
REQ-045 Assert reset mid-period with a write pending -> all outputs 0 and half=DEFAULT_HALF_NS next cycle; pending cleared.
